// File: rtl/alu_result_writer_pkg.sv
// Shared definitions for the ALU result writer: default data width,
// lane geometry of a result group and the serializer state encoding.
package alu_result_writer_pkg;

  // Default width of one accumulated result / RAM word
  localparam int DATA_W_DEF = 18;

  // A group carries one result per MAC lane (MU1..MU4)
  localparam int LANES     = 4;
  localparam int LANE_W    = 2;
  localparam int LANE_LAST = LANES - 1;

  // RAM address layout, LSB first: lane (LANE_W bits), group, bank (1 bit)
  localparam int ADDR_LANE_LSB = 0;
  localparam int ADDR_GRP_LSB  = ADDR_LANE_LSB + LANE_W;

  // Serializer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_result_fifo.sv
// Two-entry group buffer. Each entry holds one full result group plus its
// end-of-frame flag. A push is accepted when an entry is free or the head
// is being popped in the same cycle, so back-to-back groups never collide
// with the serializer freeing a slot.
module alu_result_fifo #(
  parameter int W = 73
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage, pointers and occupancy count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/alu_result_writer.sv
// Result-side companion of the 4-lane MAC ALU. Captures each result group
// one cycle after four_results_ready, buffers up to two groups and writes
// them one word per cycle into a dual-bank result RAM addressed as
// {bank, group, lane}. The last group of a frame produces a frame_done
// pulse and flips the bank.
// Optional feature: define RESULT_MAX_EN to track the largest word written
// in each frame (max_val/max_addr); otherwise both outputs are tied to 0.
module alu_result_writer
  import alu_result_writer_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int GROUPS_LOG2 = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        MU1,
  input  logic [DATA_W-1:0]        MU2,
  input  logic [DATA_W-1:0]        MU3,
  input  logic [DATA_W-1:0]        MU4,
  input  logic                     four_results_ready,
  input  logic                     all_results_ready,
  output logic                     ram_en,
  output logic [GROUPS_LOG2+2:0]   ram_addr,
  output logic [DATA_W-1:0]        ram_wdata,
  output logic                     frame_done,
  output logic                     done_bank,
  output logic                     busy,
  output logic                     overflow,
  output logic [DATA_W-1:0]        max_val,
  output logic [GROUPS_LOG2+2:0]   max_addr
);

  localparam int ADDR_W  = GROUPS_LOG2 + 3;
  localparam int ENTRY_W = LANES * DATA_W + 1;

  // Capture stage
  logic pend_q;
  logic pend_last_q;

  // Group buffer
  logic [ENTRY_W-1:0] entry_in;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic [ENTRY_W-1:0] head_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic [1:0]         fifo_count;
  logic               pop;
  logic               push_acc;
  logic [1:0]         count_after;
  logic               head_last;
  logic [DATA_W-1:0]  head_word [LANES];

  // Serializer
  state_e                 state_q;
  logic [LANE_W-1:0]      lane_q;
  logic [GROUPS_LOG2-1:0] grp_q;
  logic                   bank_q;
  logic                   ram_en_q;
  logic [ADDR_W-1:0]      ram_addr_q;
  logic [DATA_W-1:0]      ram_wdata_q;
  logic                   frame_done_q;
  logic                   done_bank_q;
  logic                   busy_q;
  logic                   overflow_q;

  // Remember the ready pulse; lane results become final one cycle later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      pend_q      <= four_results_ready;
      pend_last_q <= four_results_ready && all_results_ready;
    end
  end

  assign entry_in = {pend_last_q, MU4, MU3, MU2, MU1};

  // The head entry is freed while its last lane is being issued
  assign pop         = (state_q == ST_WRITE) && (lane_q == LANE_W'(LANE_LAST));
  assign push_acc    = pend_q && (!fifo_full || pop);
  assign count_after = fifo_count + {1'b0, push_acc} - {1'b0, pop};

  alu_result_fifo #(
    .W (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (pend_q),
    .data_i  (entry_in),
    .pop_i   (pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // With an empty buffer the group being captured this cycle is issued
  // directly, which gives the two-cycle ready-to-first-write latency.
  assign head_data = fifo_empty ? entry_in : fifo_rdata;
  assign head_last = head_data[ENTRY_W-1];

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign head_word[gi] = head_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Sticky drop flag: capture into a full buffer that is not freeing a slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else if (pend_q && fifo_full && !pop) begin
      overflow_q <= 1'b1;
    end
  end

  // Serializer FSM with registered RAM port and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      lane_q       <= '0;
      grp_q        <= '0;
      bank_q       <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      frame_done_q <= 1'b0;
      done_bank_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      ram_en_q     <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty || pend_q) begin
            ram_en_q    <= 1'b1;
            ram_addr_q  <= {bank_q, grp_q, {LANE_W{1'b0}}};
            ram_wdata_q <= head_word[0];
            lane_q      <= LANE_W'(1);
            state_q     <= ST_WRITE;
            busy_q      <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_WRITE: begin
          ram_en_q    <= 1'b1;
          ram_addr_q  <= {bank_q, grp_q, lane_q};
          ram_wdata_q <= head_word[lane_q];
          busy_q      <= 1'b1;
          if (lane_q == LANE_W'(LANE_LAST)) begin
            lane_q <= '0;
            grp_q  <= grp_q + GROUPS_LOG2'(1);
            if (head_last) begin
              state_q <= ST_DONE;
            end else if (count_after != 2'd0) begin
              state_q <= ST_WRITE;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            lane_q <= lane_q + LANE_W'(1);
          end
        end
        ST_DONE: begin
          frame_done_q <= 1'b1;
          done_bank_q  <= bank_q;
          bank_q       <= ~bank_q;
          grp_q        <= '0;
          lane_q       <= '0;
          busy_q       <= (count_after != 2'd0);
          state_q      <= (count_after != 2'd0) ? ST_WRITE : ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ram_en     = ram_en_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign frame_done = frame_done_q;
  assign done_bank  = done_bank_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;

`ifdef RESULT_MAX_EN
  logic [DATA_W-1:0] max_val_q;
  logic [ADDR_W-1:0] max_addr_q;

  // Running max of the words written this frame; strict compare keeps the
  // first occurrence, and the pair is cleared once frame_done has been seen
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_val_q  <= '0;
      max_addr_q <= '0;
    end else if (frame_done_q) begin
      max_val_q  <= '0;
      max_addr_q <= '0;
    end else if (ram_en_q && (ram_wdata_q > max_val_q)) begin
      max_val_q  <= ram_wdata_q;
      max_addr_q <= ram_addr_q;
    end
  end

  assign max_val  = max_val_q;
  assign max_addr = max_addr_q;
`else
  assign max_val  = '0;
  assign max_addr = '0;
`endif

endmodule

// File: tb/tb_alu_result_writer.sv
// Directed testbench for alu_result_writer. Expectations are hand-derived
// from the timing contract: ready in cycle t, MU values in t+1, writes in
// t+2..t+5, frame_done in t+6. Max-tracking expectations follow the
// RESULT_MAX_EN build option.
module tb_alu_result_writer;

`ifdef RESULT_MAX_EN
  localparam bit MAX_EN = 1'b1;
`else
  localparam bit MAX_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [17:0] MU1 = '0, MU2 = '0, MU3 = '0, MU4 = '0;
  logic        four_results_ready = 1'b0;
  logic        all_results_ready  = 1'b0;
  logic        ram_en;
  logic [4:0]  ram_addr;
  logic [17:0] ram_wdata;
  logic        frame_done;
  logic        done_bank;
  logic        busy;
  logic        overflow;
  logic [17:0] max_val;
  logic [4:0]  max_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_result_writer dut (
    .clk                (clk),
    .rst                (rst),
    .MU1                (MU1),
    .MU2                (MU2),
    .MU3                (MU3),
    .MU4                (MU4),
    .four_results_ready (four_results_ready),
    .all_results_ready  (all_results_ready),
    .ram_en             (ram_en),
    .ram_addr           (ram_addr),
    .ram_wdata          (ram_wdata),
    .frame_done         (frame_done),
    .done_bank          (done_bank),
    .busy               (busy),
    .overflow           (overflow),
    .max_val            (max_val),
    .max_addr           (max_addr)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int addr, input int data);
    chk({tag, ".ram_en"}, 32'(ram_en), 32'd1);
    chk({tag, ".ram_addr"}, 32'(ram_addr), 32'(addr));
    chk({tag, ".ram_wdata"}, 32'(ram_wdata), 32'(data));
  endtask

  // One isolated group: ready pulse now (cycle t), values in t+1, checks
  // writes in t+2..t+5 and the frame_done state in t+6. Returns in t+6.
  task automatic do_group(input string tag, input int a0,
                          input int v0, input int v1, input int v2, input int v3,
                          input logic last, input logic exp_bank);
    four_results_ready = 1'b1;
    all_results_ready  = last;
    tick();
    four_results_ready = 1'b0;
    all_results_ready  = 1'b0;
    MU1 = 18'(v0); MU2 = 18'(v1); MU3 = 18'(v2); MU4 = 18'(v3);
    tick();
    MU1 = '0; MU2 = '0; MU3 = '0; MU4 = '0;
    chk_wr({tag, ".l0"}, a0, v0);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    tick();
    chk_wr({tag, ".l1"}, a0 + 1, v1);
    tick();
    chk_wr({tag, ".l2"}, a0 + 2, v2);
    tick();
    chk_wr({tag, ".l3"}, a0 + 3, v3);
    chk({tag, ".fd_early"}, 32'(frame_done), 32'd0);
    tick();
    chk({tag, ".ram_en_end"}, 32'(ram_en), 32'd0);
    chk({tag, ".frame_done"}, 32'(frame_done), 32'(last));
    chk({tag, ".busy_end"}, 32'(busy), 32'd0);
    if (last) chk({tag, ".done_bank"}, 32'(done_bank), 32'(exp_bank));
    $display("group %s base_addr=%0d last=%0d words=%0d,%0d,%0d,%0d",
             tag, a0, last, v0, v1, v2, v3);
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick();
    tick();
    chk("rst.ram_en", 32'(ram_en), 32'd0);
    chk("rst.ram_addr", 32'(ram_addr), 32'd0);
    chk("rst.ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rst.frame_done", 32'(frame_done), 32'd0);
    chk("rst.done_bank", 32'(done_bank), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.overflow", 32'(overflow), 32'd0);
    chk("rst.max_val", 32'(max_val), 32'd0);
    chk("rst.max_addr", 32'(max_addr), 32'd0);
    rst = 1'b1;
    tick();
    tick();
    chk("idle.ram_en", 32'(ram_en), 32'd0);

    // ---------------- single group ----------------
    do_group("single", 0, 10, 20, 30, 40, 1'b0, 1'b0);
    tick();

    // ---------------- reset mid-write ----------------
    four_results_ready = 1'b1;
    tick();
    four_results_ready = 1'b0;
    MU1 = 18'd7; MU2 = 18'd8; MU3 = 18'd9; MU4 = 18'd11;
    tick();
    MU1 = '0; MU2 = '0; MU3 = '0; MU4 = '0;
    chk_wr("midrst.l0", 4, 7);
    tick();
    chk_wr("midrst.l1", 5, 8);
    tick();
    chk_wr("midrst.l2", 6, 9);
    rst = 1'b0;
    #1;
    chk("midrst.ram_en", 32'(ram_en), 32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.ram_addr", 32'(ram_addr), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // ---------------- frame 1 (bank 0), max at 6 and 9 ----------------
    do_group("f1g0", 0, 1, 2, 3, 4, 1'b0, 1'b0);
    chk("f1g0.max_val", 32'(max_val), MAX_EN ? 32'd4 : 32'd0);
    chk("f1g0.max_addr", 32'(max_addr), MAX_EN ? 32'd3 : 32'd0);
    tick(); tick();
    do_group("f1g1", 4, 5, 6, 262143, 8, 1'b0, 1'b0);
    tick(); tick();
    do_group("f1g2", 8, 9, 262143, 11, 12, 1'b0, 1'b0);
    tick(); tick();
    do_group("f1g3", 12, 13, 14, 15, 16, 1'b1, 1'b0);
    chk("f1.max_val", 32'(max_val), MAX_EN ? 32'd262143 : 32'd0);
    chk("f1.max_addr", 32'(max_addr), MAX_EN ? 32'd6 : 32'd0);
    tick();
    chk("f1.fd_pulse", 32'(frame_done), 32'd0);
    chk("f1.max_clr", 32'(max_val), 32'd0);
    chk("f1.maxaddr_clr", 32'(max_addr), 32'd0);
    tick();

    // ---------------- frame 2 (bank 1) ----------------
    for (int g = 0; g < 4; g++) begin
      do_group($sformatf("f2g%0d", g), 16 + 4 * g,
               1000 + 10 * g, 1001 + 10 * g, 1002 + 10 * g, 1003 + 10 * g,
               (g == 3), 1'b1);
      tick(); tick();
    end
    tick();

    // ---------------- overflow: three ready pulses back to back ----------------
    four_results_ready = 1'b1;
    tick();
    MU1 = 18'd50; MU2 = 18'd51; MU3 = 18'd52; MU4 = 18'd53;
    tick();
    chk_wr("ovf.a0", 0, 50);
    MU1 = 18'd60; MU2 = 18'd61; MU3 = 18'd62; MU4 = 18'd63;
    tick();
    chk_wr("ovf.a1", 1, 51);
    chk("ovf.not_yet", 32'(overflow), 32'd0);
    MU1 = 18'd70; MU2 = 18'd71; MU3 = 18'd72; MU4 = 18'd73;
    four_results_ready = 1'b0;
    tick();
    MU1 = '0; MU2 = '0; MU3 = '0; MU4 = '0;
    chk_wr("ovf.a2", 2, 52);
    chk("ovf.set", 32'(overflow), 32'd1);
    tick();
    chk_wr("ovf.a3", 3, 53);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_wr($sformatf("ovf.b%0d", i), 4 + i, 60 + i);
    end
    tick();
    chk("ovf.end_en", 32'(ram_en), 32'd0);
    chk("ovf.end_busy", 32'(busy), 32'd0);
    chk("ovf.end_fd", 32'(frame_done), 32'd0);
    tick();
    chk("ovf.no_third", 32'(ram_en), 32'd0);
    chk("ovf.held", 32'(overflow), 32'd1);
    $display("overflow sequence: groups at addr 0..7 written, third dropped");

    // ---------------- all_results_ready alone ----------------
    all_results_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("allonly.en%0d", i), 32'(ram_en), 32'd0);
      chk($sformatf("allonly.fd%0d", i), 32'(frame_done), 32'd0);
    end
    all_results_ready = 1'b0;
    tick();
    tick();
    chk("allonly.tail_en", 32'(ram_en), 32'd0);
    chk("allonly.ovf_held", 32'(overflow), 32'd1);

    // ---------------- reset clears overflow ----------------
    rst = 1'b0;
    #1;
    chk("rst2.overflow", 32'(overflow), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("rst2.overflow_after", 32'(overflow), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
